// File: rtl/dma_axi_copy_engine.sv
// AXI4 DMA copy engine: splits a beat-count copy into bursts capped by MAX_BURST and by
// 4 KB boundaries, staging each read burst in a local buffer before writing it back out.
module dma_axi_copy_engine #(
    parameter int AXI_ID_WIDTH   = 4,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int MAX_BURST      = 16,
    parameter int DMA_ID         = 3,
    parameter int LEN_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [AXI_ADDR_WIDTH-1:0] src_addr,
    input  logic [AXI_ADDR_WIDTH-1:0] dst_addr,
    input  logic [LEN_WIDTH-1:0]      len_beats,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [AXI_ID_WIDTH-1:0]   awid,
    output logic [AXI_ADDR_WIDTH-1:0] awaddr,
    output logic [7:0]                awlen,
    output logic                      awvalid,
    input  logic                      awready,
    output logic [AXI_DATA_WIDTH-1:0] wdata,
    output logic                      wlast,
    output logic                      wvalid,
    input  logic                      wready,
    input  logic [AXI_ID_WIDTH-1:0]   bid,
    input  logic [1:0]                bresp,
    input  logic                      bvalid,
    output logic                      bready,
    output logic [AXI_ID_WIDTH-1:0]   arid,
    output logic [AXI_ADDR_WIDTH-1:0] araddr,
    output logic [7:0]                arlen,
    output logic                      arvalid,
    input  logic                      arready,
    input  logic [AXI_ID_WIDTH-1:0]   rid,
    input  logic [AXI_DATA_WIDTH-1:0] rdata,
    input  logic [1:0]                rresp,
    input  logic                      rvalid,
    input  logic                      rlast,
    output logic                      rready
);
    localparam int BPW = AXI_DATA_WIDTH / 8;
    localparam int OFF = $clog2(BPW);
    localparam int IW  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [8:0] MB = 9'(MAX_BURST);
    localparam logic [AXI_ADDR_WIDTH-1:0] AMASK = ~AXI_ADDR_WIDTH'(BPW - 1);

    typedef enum logic [2:0] {IDLE, CALC, AR, R, AW, W, B, DONE} state_t;

    state_t                    state;
    logic [AXI_ADDR_WIDTH-1:0] src, dst;
    logic [LEN_WIDTH-1:0]      rem;
    logic [8:0]                bl, cnt;
    logic [AXI_DATA_WIDTH-1:0] stage_mem [MAX_BURST];

    logic [12:0] src_room, dst_room;
    logic [8:0]  rem_c, src_c, dst_c, min_a, bl_calc;
    logic        last_beat, unused_ok;

    assign unused_ok = ^{bid, rid};
    assign last_beat = (cnt == bl - 9'd1);

    // Every term is clamped to MAX_BURST first so the minimum fits the 9-bit burst counter.
    always_comb begin
        src_room = (13'd4096 - {1'b0, src[11:0]}) >> OFF;
        dst_room = (13'd4096 - {1'b0, dst[11:0]}) >> OFF;
        rem_c    = (rem >= LEN_WIDTH'(MAX_BURST)) ? MB : 9'(rem);
        src_c    = (src_room >= 13'(MAX_BURST)) ? MB : src_room[8:0];
        dst_c    = (dst_room >= 13'(MAX_BURST)) ? MB : dst_room[8:0];
        min_a    = (rem_c < src_c) ? rem_c : src_c;
        bl_calc  = (min_a < dst_c) ? min_a : dst_c;
    end

    always_ff @(posedge clk) begin
        if (state == R && rvalid && rready)
            stage_mem[cnt[IW-1:0]] <= rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            src     <= '0;
            dst     <= '0;
            rem     <= '0;
            bl      <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            error   <= 1'b0;
            awid    <= AXI_ID_WIDTH'(DMA_ID);
            arid    <= AXI_ID_WIDTH'(DMA_ID);
            awaddr  <= '0;
            awlen   <= '0;
            awvalid <= 1'b0;
            wdata   <= '0;
            wlast   <= 1'b0;
            wvalid  <= 1'b0;
            bready  <= 1'b0;
            araddr  <= '0;
            arlen   <= '0;
            arvalid <= 1'b0;
            rready  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        src   <= src_addr & AMASK;
                        dst   <= dst_addr & AMASK;
                        rem   <= len_beats;
                        error <= 1'b0;
                        busy  <= 1'b1;
                        state <= (len_beats == '0) ? DONE : CALC;
                    end
                end
                CALC: begin
                    bl      <= bl_calc;
                    araddr  <= src;
                    arlen   <= 8'(bl_calc - 9'd1);
                    arvalid <= 1'b1;
                    state   <= AR;
                end
                AR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        cnt     <= '0;
                        state   <= R;
                    end
                end
                R: begin
                    if (rvalid) begin
                        cnt <= cnt + 9'd1;
                        // Burst ends on rlast or the bl-th beat; disagreement between them is an error.
                        if (rresp != 2'b00 || ((rlast || last_beat) && (rlast != last_beat)))
                            error <= 1'b1;
                        if (rlast || last_beat) begin
                            rready  <= 1'b0;
                            awaddr  <= dst;
                            awlen   <= 8'(bl - 9'd1);
                            awvalid <= 1'b1;
                            state   <= AW;
                        end
                    end
                end
                AW: begin
                    if (awready) begin
                        awvalid <= 1'b0;
                        wvalid  <= 1'b1;
                        wdata   <= stage_mem[0];
                        wlast   <= (bl == 9'd1);
                        cnt     <= 9'd1;
                        state   <= W;
                    end
                end
                W: begin
                    if (wready) begin
                        if (wlast) begin
                            wvalid <= 1'b0;
                            wlast  <= 1'b0;
                            bready <= 1'b1;
                            state  <= B;
                        end else begin
                            wdata <= stage_mem[cnt[IW-1:0]];
                            wlast <= last_beat;
                            cnt   <= cnt + 9'd1;
                        end
                    end
                end
                B: begin
                    if (bvalid) begin
                        bready <= 1'b0;
                        if (bresp != 2'b00)
                            error <= 1'b1;
                        src <= src + (AXI_ADDR_WIDTH'(bl) << OFF);
                        dst <= dst + (AXI_ADDR_WIDTH'(bl) << OFF);
                        rem <= rem - LEN_WIDTH'(bl);
                        if (rem == LEN_WIDTH'(bl) || error || bresp != 2'b00)
                            state <= DONE;
                        else
                            state <= CALC;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
